// File: rtl/recv_word_buffer.sv
// Receive word buffer: packs UART RX bytes into 32-bit little-endian words and
// queues them in a circular FIFO. Optional sticky drop flag: RECV_OVERFLOW_FLAG_EN.
module recv_word_buffer #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        en,
  output logic [31:0] rd,
  output logic [31:0] size,
  output logic        overflow
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]    mem [2**DEPTH_LOG2];

  logic [1:0]     bc_q, bc_d;
  logic [23:0]    partial_q, partial_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [PW-1:0]  size_q, size_d;
  logic [31:0]    rd_q;
  logic [31:0]    word;
  logic           push_req, push_ok, pop_ok;

  assign word = {rx_byte, partial_q};

  always_comb begin
    bc_d      = bc_q;
    partial_d = partial_q;
    pop_ok    = en && (size_q != '0);
    push_req  = rx_valid && (bc_q == 2'd3);
    // At full, a same-cycle pop frees the slot the push is about to use.
    push_ok   = push_req && ((size_q != DEPTH) || pop_ok);
    if (rx_valid) begin
      if (bc_q == 2'd3) begin
        bc_d = 2'd0;
      end else begin
        bc_d = bc_q + 2'd1;
        case (bc_q)
          2'd0:    partial_d[7:0]   = rx_byte;
          2'd1:    partial_d[15:8]  = rx_byte;
          2'd2:    partial_d[23:16] = rx_byte;
          default: ;
        endcase
      end
    end
    wptr_d = wptr_q + PW'(push_ok);
    rptr_d = rptr_q + PW'(pop_ok);
    size_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bc_q      <= 2'd0;
      partial_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      size_q    <= '0;
      rd_q      <= '0;
    end else begin
      bc_q      <= bc_d;
      partial_q <= partial_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      size_q    <= size_d;
      // Read-before-write: at full with push+pop the same slot is read old, then overwritten.
      if (pop_ok) rd_q <= mem[rptr_q[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr_q[DEPTH_LOG2-1:0]] <= word;
  end

  assign rd   = rd_q;
  assign size = 32'(size_q);

`ifdef RECV_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (push_req & ~push_ok);

  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_recv_word_buffer.sv
// Directed bench for recv_word_buffer with a 4-word FIFO (DEPTH_LOG2=2).
module tb_recv_word_buffer;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        en;
  logic [31:0] rd;
  logic [31:0] size;
  logic        overflow;

  int checks = 0;
  int errors = 0;

`ifdef RECV_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  recv_word_buffer #(.DEPTH_LOG2(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .en       (en),
    .rd       (rd),
    .size     (size),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pop_once();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h expected %h", rd, 32'd0); end
    checks++;
    if (size !== 32'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", size); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    checks++;
    if (size !== 32'd0) begin errors++; $display("FAIL single_size_3bytes: got %0d expected 0", size); end
    send_byte(8'h12);
    checks++;
    if (size !== 32'd1) begin errors++; $display("FAIL single_size_4bytes: got %0d expected 1", size); end
    pop_once();
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL single_rd: got %h expected %h", rd, 32'h12345678); end
    checks++;
    if (size !== 32'd0) begin errors++; $display("FAIL single_size_after_pop: got %0d expected 0", size); end
  endtask

  task automatic test_ordering();
    do_reset();
    for (int i = 1; i <= 3; i++) push_word(32'(i));
    checks++;
    if (size !== 32'd3) begin errors++; $display("FAIL order_size_full: got %0d expected 3", size); end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (rd !== 32'(i)) begin errors++; $display("FAIL order_rd%0d: got %h expected %h", i, rd, 32'(i)); end
      checks++;
      if (size !== 32'(3 - i)) begin errors++; $display("FAIL order_size%0d: got %0d expected %0d", i, size, 3 - i); end
    end
    en = 1'b0;
  endtask

  task automatic test_empty_pop();
    do_reset();
    push_word(32'hDEADBEEF);
    pop_once();
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL empty_setup_rd: got %h expected %h", rd, 32'hDEADBEEF); end
    pop_once();
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL empty_rd_held: got %h expected %h", rd, 32'hDEADBEEF); end
    checks++;
    if (size !== 32'd0) begin errors++; $display("FAIL empty_size: got %0d expected 0", size); end
    // Read pointer must not have moved on the empty pop.
    push_word(32'hCAFEF00D);
    pop_once();
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL empty_next_rd: got %h expected %h", rd, 32'hCAFEF00D); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'hA + 32'(i));
    checks++;
    if (size !== 32'd4) begin errors++; $display("FAIL full_size4: got %0d expected 4", size); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_before: got %b expected 0", overflow); end
    push_word(32'hE);
    checks++;
    if (size !== 32'd4) begin errors++; $display("FAIL full_size_after_drop: got %0d expected 4", size); end
    checks++;
    if (overflow !== OVF_EXP) begin errors++; $display("FAIL full_ovf_after: got %b expected %b", overflow, OVF_EXP); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rd !== 32'hA + 32'(i)) begin errors++; $display("FAIL full_rd%0d: got %h expected %h", i, rd, 32'hA + 32'(i)); end
      checks++;
      if (size !== 32'(3 - i)) begin errors++; $display("FAIL full_size_pop%0d: got %0d expected %0d", i, size, 3 - i); end
    end
    tick();
    en = 1'b0;
    checks++;
    if (rd !== 32'hD) begin errors++; $display("FAIL full_rd_after_empty: got %h expected %h", rd, 32'hD); end
    checks++;
    if (overflow !== OVF_EXP) begin errors++; $display("FAIL full_ovf_sticky: got %b expected %b", overflow, OVF_EXP); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp_q [5];
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'hA + 32'(i));
    send_byte(8'h0F);
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b1;
    rx_byte  = 8'h00;
    en       = 1'b1;
    tick();
    rx_valid = 1'b0;
    en       = 1'b0;
    checks++;
    if (rd !== 32'hA) begin errors++; $display("FAIL pp_rd0: got %h expected %h", rd, 32'hA); end
    checks++;
    if (size !== 32'd4) begin errors++; $display("FAIL pp_size: got %0d expected 4", size); end
    exp_q[0] = 32'hB; exp_q[1] = 32'hC; exp_q[2] = 32'hD; exp_q[3] = 32'hF;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rd !== exp_q[i]) begin errors++; $display("FAIL pp_rd%0d: got %h expected %h", i + 1, rd, exp_q[i]); end
      checks++;
      if (size !== 32'(3 - i)) begin errors++; $display("FAIL pp_size_pop%0d: got %0d expected %0d", i, size, 3 - i); end
    end
    en = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    push_word(32'h01020304);
    push_word(32'h05060708);
    pop_once();
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if (size !== 32'd1) begin errors++; $display("FAIL mid_size_before: got %0d expected 1", size); end
    do_reset();
    checks++;
    if (size !== 32'd0) begin errors++; $display("FAIL mid_size_reset: got %0d expected 0", size); end
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL mid_rd_reset: got %h expected 0", rd); end
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    checks++;
    if (size !== 32'd1) begin errors++; $display("FAIL mid_size_after: got %0d expected 1", size); end
    pop_once();
    checks++;
    if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL mid_rd: got %h expected %h", rd, 32'hDDCCBBAA); end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    en       = 1'b0;
    tick();
    test_reset();
    test_single_word();
    test_ordering();
    test_empty_pop();
    test_full_overflow();
    test_push_pop_full();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
